exu_bjp_unit: RTL and testbench
===============================

Name: exu_bjp_unit

Overview:
- Parametrised, buffered successor to the single-cycle BJP path: resolves JAL/JALR and all six conditional branches internally, with no ALU borrowing.
- Per instruction, computes:
  - the condition outcome;
  - the target;
  - the link value (pc+4);
  - a misprediction flag and redirect PC versus the decode-time prediction.
- Results pass through a registered DEPTH-entry output FIFO with valid/ready handshake, feeding commit and writeback.
- Sits in EXU between dispatch and commit, parallel to the regular ALU.

Parameters:
- XLEN, 32, operand/writeback width.
- PC_SIZE, 32, PC width (PC_SIZE <= XLEN).
- DEPTH, 2, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- bjp_i_valid  in  1  request valid.
- bjp_i_ready  out  1  request accepted when valid&ready.
- bjp_i_rs1  in  XLEN  source 1.
- bjp_i_rs2  in  XLEN  source 2.
- bjp_i_imm  in  XLEN  sign-extended immediate.
- bjp_i_pc  in  PC_SIZE  instruction PC.
- bjp_i_info  in  BJP_INFO_W  decoded op fields (package).
- bjp_i_flush  in  1  pipeline flush; clears FIFO.
- bjp_o_valid  out  1  result valid.
- bjp_o_ready  in  1  consumer ready.
- bjp_o_wbck_en  out  1  write link to rd (jumps only).
- bjp_o_wbck_wdat  out  XLEN  link value, pc+4 zero-extended.
- bjp_o_cmt_bjp  out  1  entry is a jump/branch.
- bjp_o_cmt_prdt  out  1  decode prediction echoed.
- bjp_o_taken  out  1  resolved outcome.
- bjp_o_mispred  out  1  taken != prdt.
- bjp_o_redirect_pc  out  PC_SIZE  correct next PC: target if taken, else pc+4.

Behaviour:
- Reset: FIFO empty, pointers/count 0.
  - Reset values: bjp_o_valid=0, bjp_i_ready=1; all data outputs 0 (FIFO storage reset to 0).
- Handshake:
  - bjp_i_ready = !full, independent of bjp_i_valid.
  - Push on bjp_i_valid&bjp_i_ready. Pop on bjp_o_valid&bjp_o_ready.
  - bjp_o_valid = !empty. Outputs come from the FIFO head register.
- Latency: exactly 1 cycle from accept to bjp_o_valid when the FIFO was empty; no combinational input->output path.
- Simultaneous push and pop:
  - Non-full: count unchanged, entries stay in order.
  - Full: no push; ready stays 0 that cycle, rises next cycle.
- Flush: synchronous. Next cycle, count=0 and pointers=0. A same-cycle push is discarded and a same-cycle pop is ignored.
- Reset mid-operation: all in-flight entries are dropped immediately (asynchronous).
- Pointers are log2(DEPTH)-bit and wrap naturally. Count is log2(DEPTH)+1 bits.
- Condition evaluation:
  - BEQ/BNE: rs1 ==/!= rs2.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - JUMP (JAL or JALR): taken=1.
- Target computation (mod 2^PC_SIZE):
  - JAL and branches: pc+imm[PC_SIZE-1:0].
  - JALR: (rs1+imm)[PC_SIZE-1:0] with bit0 cleared.
- Link: pc+4 mod 2^PC_SIZE, zero-extended to XLEN.
  - wbck_en = JUMP.
  - For branches, wdat is still the link value but wbck_en=0.
- Mispredict: mispred = taken ^ BPRDT; redirect_pc is valid regardless of mispred.
- Illegal info (no op bit, or more than one op bit set):
  - treated as not-taken branch, cmt_bjp=1, wbck_en=0;
  - logic must not hang or X.
- cmt_bjp=1 for every entry.

Optional Feature:
- Macro BJP_PERF_EN.
- Defined: adds outputs bjp_o_perf_cnt[31:0] and bjp_o_perf_mis[31:0].
  - Increment on each pop (count) and each popped mispred entry.
  - Wrap at 2^32. Reset to 0. Not cleared by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/defines holds:
  - BJP_INFO_W=9;
  - bit indices BJP_JUMP, BJP_JALR, BJP_BEQ, BJP_BNE, BJP_BLT, BJP_BGE, BJP_BLTU, BJP_BGEU, BJP_BPRDT;
  - FIFO entry field widths.
- One natural sub-module, exu_bjp_fifo: parametrised DEPTH×WIDTH sync FIFO with flush. Resolve logic stays combinational in the top.

Test Plan:
- Reset, then BEQ rs1=5 rs2=5 pc=0x100 imm=0x20 prdt=0 -> next cycle o_valid=1, taken=1, mispred=1, redirect_pc=0x120, wbck_en=0.
- JALR rs1=0x2003 imm=4 pc=0x80 prdt=1 -> redirect_pc=0x2006, wbck_en=1, wdat=0x84, mispred=0.
- BLT rs1=0xFFFFFFFF rs2=1 -> taken=1. BLTU with the same operands -> taken=0, redirect_pc=pc+4.
- Hold o_ready=0, push 3 requests (DEPTH=2) -> i_ready=0 after 2; the third is accepted the cycle after the first pop; output order is preserved.
- Flush asserted with a full FIFO and i_valid=1 -> next cycle o_valid=0, i_ready=1, input dropped.
- With BJP_PERF_EN: pop 4 entries, 1 mispredicted -> perf_cnt=4, perf_mis=1. Assert rst mid-stream -> both 0 and o_valid=0 immediately.

Source files
------------

// File: rtl/exu_bjp_pkg.sv
// Shared definitions for the branch/jump resolve unit: decoded-info bit layout and the
// layout of a result entry held in the output FIFO.
package exu_bjp_pkg;

  localparam int unsigned BJP_INFO_W = 9;

  localparam int unsigned BJP_JUMP  = 0;
  localparam int unsigned BJP_JALR  = 1;
  localparam int unsigned BJP_BEQ   = 2;
  localparam int unsigned BJP_BNE   = 3;
  localparam int unsigned BJP_BLT   = 4;
  localparam int unsigned BJP_BGE   = 5;
  localparam int unsigned BJP_BLTU  = 6;
  localparam int unsigned BJP_BGEU  = 7;
  localparam int unsigned BJP_BPRDT = 8;

  // Single-bit result flags carried alongside the link value and redirect PC
  typedef struct packed {
    logic cmt_bjp;
    logic prdt;
    logic taken;
    logic mispred;
    logic wbck_en;
  } bjp_flags_t;

  localparam int unsigned BJP_FLAG_W = 5;

  function automatic int unsigned bjp_entry_w(input int unsigned xlen, input int unsigned pc_size);
    return BJP_FLAG_W + xlen + pc_size;
  endfunction

endpackage

// File: rtl/exu_bjp_fifo.sv
// Registered DEPTH x WIDTH synchronous FIFO with synchronous flush; storage resets to zero
// so the head register reads as zero while empty after reset.
module exu_bjp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Flush wins over any same-cycle push or pop
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/exu_bjp_unit.sv
// Branch/jump resolve unit: evaluates condition, target, link and misprediction, then buffers
// results in an output FIFO. Define BJP_PERF_EN to add pop/mispredict performance counters.
module exu_bjp_unit
  import exu_bjp_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bjp_i_valid,
  output logic                  bjp_i_ready,
  input  logic [XLEN-1:0]       bjp_i_rs1,
  input  logic [XLEN-1:0]       bjp_i_rs2,
  input  logic [XLEN-1:0]       bjp_i_imm,
  input  logic [PC_SIZE-1:0]    bjp_i_pc,
  input  logic [BJP_INFO_W-1:0] bjp_i_info,
  input  logic                  bjp_i_flush,
  output logic                  bjp_o_valid,
  input  logic                  bjp_o_ready,
  output logic                  bjp_o_wbck_en,
  output logic [XLEN-1:0]       bjp_o_wbck_wdat,
  output logic                  bjp_o_cmt_bjp,
  output logic                  bjp_o_cmt_prdt,
  output logic                  bjp_o_taken,
  output logic                  bjp_o_mispred,
  output logic [PC_SIZE-1:0]    bjp_o_redirect_pc
`ifdef BJP_PERF_EN
  ,
  output logic [31:0]           bjp_o_perf_cnt,
  output logic [31:0]           bjp_o_perf_mis
`endif
);

  localparam int unsigned EntryW = bjp_entry_w(XLEN, PC_SIZE);

  logic [6:0]         w_ops;
  logic               w_legal;
  logic               w_eq;
  logic               w_lt;
  logic               w_ltu;
  logic               w_taken;
  logic               w_is_jalr;
  logic [PC_SIZE-1:0] w_pc_tgt;
  logic [PC_SIZE-1:0] w_jalr_tgt;
  logic [PC_SIZE-1:0] w_link;
  logic [PC_SIZE-1:0] w_redirect;
  logic [XLEN-1:0]    w_link_x;
  bjp_flags_t         w_flags;
  bjp_flags_t         w_head_flags;
  logic [EntryW-1:0]  w_wdata;
  logic [EntryW-1:0]  w_rdata;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  assign w_ops = {bjp_i_info[BJP_BGEU], bjp_i_info[BJP_BLTU], bjp_i_info[BJP_BGE],
                  bjp_i_info[BJP_BLT], bjp_i_info[BJP_BNE], bjp_i_info[BJP_BEQ],
                  bjp_i_info[BJP_JUMP]};
  // Zero or multiple op bits degrade to a not-taken branch
  assign w_legal = $onehot(w_ops);

  assign w_eq  = (bjp_i_rs1 == bjp_i_rs2);
  assign w_lt  = ($signed(bjp_i_rs1) < $signed(bjp_i_rs2));
  assign w_ltu = (bjp_i_rs1 < bjp_i_rs2);

  assign w_taken = w_legal & ( bjp_i_info[BJP_JUMP]
                             | (bjp_i_info[BJP_BEQ]  &  w_eq)
                             | (bjp_i_info[BJP_BNE]  & ~w_eq)
                             | (bjp_i_info[BJP_BLT]  &  w_lt)
                             | (bjp_i_info[BJP_BGE]  & ~w_lt)
                             | (bjp_i_info[BJP_BLTU] &  w_ltu)
                             | (bjp_i_info[BJP_BGEU] & ~w_ltu));

  assign w_is_jalr  = w_legal & bjp_i_info[BJP_JUMP] & bjp_i_info[BJP_JALR];
  assign w_pc_tgt   = bjp_i_pc + bjp_i_imm[PC_SIZE-1:0];
  assign w_jalr_tgt = (bjp_i_rs1[PC_SIZE-1:0] + bjp_i_imm[PC_SIZE-1:0]) & ~PC_SIZE'(1);
  assign w_link     = bjp_i_pc + PC_SIZE'(4);
  assign w_redirect = w_taken ? (w_is_jalr ? w_jalr_tgt : w_pc_tgt) : w_link;

  always_comb begin
    w_link_x                = '0;
    w_link_x[PC_SIZE-1:0]   = w_link;
  end

  always_comb begin
    w_flags         = '0;
    w_flags.cmt_bjp = 1'b1;
    w_flags.prdt    = bjp_i_info[BJP_BPRDT];
    w_flags.taken   = w_taken;
    w_flags.mispred = w_taken ^ bjp_i_info[BJP_BPRDT];
    w_flags.wbck_en = w_legal & bjp_i_info[BJP_JUMP];
  end

  assign w_wdata     = {w_flags, w_link_x, w_redirect};
  assign bjp_i_ready = ~w_full;
  assign bjp_o_valid = ~w_empty;
  assign w_push      = bjp_i_valid & bjp_i_ready;
  assign w_pop       = bjp_o_valid & bjp_o_ready;

  exu_bjp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bjp_i_flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_flags, bjp_o_wbck_wdat, bjp_o_redirect_pc} = w_rdata;
  assign bjp_o_cmt_bjp  = w_head_flags.cmt_bjp;
  assign bjp_o_cmt_prdt = w_head_flags.prdt;
  assign bjp_o_taken    = w_head_flags.taken;
  assign bjp_o_mispred  = w_head_flags.mispred;
  assign bjp_o_wbck_en  = w_head_flags.wbck_en;

`ifdef BJP_PERF_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_perf_mis;
  logic        w_pop_eff;

  // A pop coinciding with a flush is discarded by the FIFO, so it is not counted either
  assign w_pop_eff = w_pop & ~bjp_i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt <= '0;
      r_perf_mis <= '0;
    end else if (w_pop_eff) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
      if (w_head_flags.mispred) begin
        r_perf_mis <= r_perf_mis + 32'd1;
      end
    end
  end

  assign bjp_o_perf_cnt = r_perf_cnt;
  assign bjp_o_perf_mis = r_perf_mis;
`endif

endmodule

// File: tb/tb_exu_bjp_unit.sv
// Self-checking bench for exu_bjp_unit: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_exu_bjp_unit;
  import exu_bjp_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_SIZE = 32;
  localparam int unsigned DEPTH   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  bjp_i_valid;
  logic                  bjp_i_ready;
  logic [XLEN-1:0]       bjp_i_rs1;
  logic [XLEN-1:0]       bjp_i_rs2;
  logic [XLEN-1:0]       bjp_i_imm;
  logic [PC_SIZE-1:0]    bjp_i_pc;
  logic [BJP_INFO_W-1:0] bjp_i_info;
  logic                  bjp_i_flush;
  logic                  bjp_o_valid;
  logic                  bjp_o_ready;
  logic                  bjp_o_wbck_en;
  logic [XLEN-1:0]       bjp_o_wbck_wdat;
  logic                  bjp_o_cmt_bjp;
  logic                  bjp_o_cmt_prdt;
  logic                  bjp_o_taken;
  logic                  bjp_o_mispred;
  logic [PC_SIZE-1:0]    bjp_o_redirect_pc;
`ifdef BJP_PERF_EN
  logic [31:0]           bjp_o_perf_cnt;
  logic [31:0]           bjp_o_perf_mis;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_bjp_unit #(
    .XLEN    (XLEN),
    .PC_SIZE (PC_SIZE),
    .DEPTH   (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bjp_i_valid       (bjp_i_valid),
    .bjp_i_ready       (bjp_i_ready),
    .bjp_i_rs1         (bjp_i_rs1),
    .bjp_i_rs2         (bjp_i_rs2),
    .bjp_i_imm         (bjp_i_imm),
    .bjp_i_pc          (bjp_i_pc),
    .bjp_i_info        (bjp_i_info),
    .bjp_i_flush       (bjp_i_flush),
    .bjp_o_valid       (bjp_o_valid),
    .bjp_o_ready       (bjp_o_ready),
    .bjp_o_wbck_en     (bjp_o_wbck_en),
    .bjp_o_wbck_wdat   (bjp_o_wbck_wdat),
    .bjp_o_cmt_bjp     (bjp_o_cmt_bjp),
    .bjp_o_cmt_prdt    (bjp_o_cmt_prdt),
    .bjp_o_taken       (bjp_o_taken),
    .bjp_o_mispred     (bjp_o_mispred),
    .bjp_o_redirect_pc (bjp_o_redirect_pc)
`ifdef BJP_PERF_EN
    ,
    .bjp_o_perf_cnt    (bjp_o_perf_cnt),
    .bjp_o_perf_mis    (bjp_o_perf_mis)
`endif
  );

  typedef struct {
    logic        taken;
    logic        mispred;
    logic        wbck_en;
    logic        prdt;
    logic [31:0] wdat;
    logic [31:0] redirect;
  } exp_t;

  // Reference model straight from the ISA rules
  function automatic exp_t model(input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [8:0] info);
    exp_t        e;
    int          nops;
    logic [31:0] target;
    int          ops [7] = '{BJP_JUMP, BJP_BEQ, BJP_BNE, BJP_BLT, BJP_BGE, BJP_BLTU, BJP_BGEU};
    nops = 0;
    foreach (ops[k]) if (info[ops[k]]) nops++;
    e.taken   = 1'b0;
    e.wbck_en = 1'b0;
    target    = pc + imm;
    if (nops == 1) begin
      if (info[BJP_JUMP]) begin
        e.taken   = 1'b1;
        e.wbck_en = 1'b1;
        if (info[BJP_JALR]) target = (rs1 + imm) & 32'hFFFF_FFFE;
      end
      else if (info[BJP_BEQ])  e.taken = (rs1 == rs2);
      else if (info[BJP_BNE])  e.taken = (rs1 != rs2);
      else if (info[BJP_BLT])  e.taken = ($signed(rs1) < $signed(rs2));
      else if (info[BJP_BGE])  e.taken = ($signed(rs1) >= $signed(rs2));
      else if (info[BJP_BLTU]) e.taken = (rs1 < rs2);
      else                     e.taken = (rs1 >= rs2);
    end
    e.prdt     = info[BJP_BPRDT];
    e.mispred  = (e.taken != e.prdt);
    e.wdat     = pc + 32'd4;
    e.redirect = e.taken ? target : pc + 32'd4;
    return e;
  endfunction

  function automatic logic [8:0] mk(input int op, input bit jalr, input bit prdt);
    logic [8:0] r;
    r            = '0;
    r[op]        = 1'b1;
    r[BJP_JALR]  = jalr;
    r[BJP_BPRDT] = prdt;
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 7));
      1:       v = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      2:       v = 32'h8000_0000 ^ 32'($urandom_range(0, 7));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [8:0] rnd_info();
    logic [8:0] r;
    int         ops [7] = '{BJP_JUMP, BJP_BEQ, BJP_BNE, BJP_BLT, BJP_BGE, BJP_BLTU, BJP_BGEU};
    int         k;
    k = $urandom_range(0, 8);
    if (k < 7)       r = mk(ops[k], (ops[k] == BJP_JUMP) && $urandom_range(0, 1) == 1, 1'b0);
    else if (k == 7) r = 9'($urandom_range(0, 255));
    else             r = '0;
    r[BJP_BPRDT] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [8:0] info);
    bjp_i_valid = v;
    bjp_i_rs1   = rs1;
    bjp_i_rs2   = rs2;
    bjp_i_imm   = imm;
    bjp_i_pc    = pc;
    bjp_i_info  = info;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bjp_o_ready = 1'b0;
    bjp_i_flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0);
    #1;
    tick();
    checks++;
    if ({bjp_o_valid, bjp_i_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_hs: got valid/ready=%b%b want 01", bjp_o_valid, bjp_i_ready);
    end
    checks++;
    if ({bjp_o_wbck_en, bjp_o_cmt_bjp, bjp_o_cmt_prdt, bjp_o_taken, bjp_o_mispred,
         bjp_o_wbck_wdat, bjp_o_redirect_pc} !== '0) begin
      failures++;
      $display("FAIL reset_data: got wdat=%h redirect=%h flags=%b%b%b%b%b want all 0",
               bjp_o_wbck_wdat, bjp_o_redirect_pc, bjp_o_wbck_en, bjp_o_cmt_bjp,
               bjp_o_cmt_prdt, bjp_o_taken, bjp_o_mispred);
    end
    rst = 1'b0;
    tick();
  endtask

  // One request at a time from empty: checks 1-cycle latency and resolved fields
  task automatic test_directed();
    logic [31:0] rs1 [6] = '{32'd5, 32'h2003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd9};
    logic [31:0] rs2 [6] = '{32'd5, 32'd0, 32'd1, 32'd1, 32'd2, 32'd9};
    logic [31:0] imm [6] = '{32'h20, 32'd4, 32'h40, 32'h40, 32'h10, 32'h10};
    logic [31:0] pc  [6] = '{32'h100, 32'h80, 32'h200, 32'h200, 32'h300, 32'h400};
    logic [8:0]  inf [6];
    exp_t        e;
    inf[0] = mk(BJP_BEQ, 1'b0, 1'b0);
    inf[1] = mk(BJP_JUMP, 1'b1, 1'b1);
    inf[2] = mk(BJP_BLT, 1'b0, 1'b0);
    inf[3] = mk(BJP_BLTU, 1'b0, 1'b1);
    inf[4] = 9'h000;
    inf[5] = mk(BJP_BEQ, 1'b0, 1'b0) | mk(BJP_JUMP, 1'b0, 1'b0);
    bjp_o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rs1[i], rs2[i], imm[i], pc[i], inf[i]);
      e = model(rs1[i], rs2[i], imm[i], pc[i], inf[i]);
      tick();
      bjp_i_valid = 1'b0;
      checks++;
      if ({bjp_o_valid, bjp_o_cmt_bjp, bjp_o_taken, bjp_o_mispred, bjp_o_wbck_en,
           bjp_o_cmt_prdt, bjp_o_redirect_pc, bjp_o_wbck_wdat} !==
          {2'b11, e.taken, e.mispred, e.wbck_en, e.prdt, e.redirect, e.wdat}) begin
        failures++;
        $display("FAIL directed_%0d: got v=%b t=%b m=%b w=%b rpc=%h wdat=%h want v=1 t=%b m=%b w=%b rpc=%h wdat=%h",
                 i, bjp_o_valid, bjp_o_taken, bjp_o_mispred, bjp_o_wbck_en, bjp_o_redirect_pc,
                 bjp_o_wbck_wdat, e.taken, e.mispred, e.wbck_en, e.redirect, e.wdat);
      end
      tick();
      checks++;
      if (bjp_o_valid !== 1'b0) begin
        failures++;
        $display("FAIL directed_drain_%0d: got valid=%b want 0", i, bjp_o_valid);
      end
    end
    // Spec vectors pinned as constants, independent of the model
    checks++;
    if (e.redirect !== 32'h404) begin
      failures++;
      $display("FAIL directed_illegal_rpc: got %h want 404", e.redirect);
    end
  endtask

  // JAL with imm=0 makes redirect_pc equal the pc, tagging each entry
  task automatic test_backpressure();
    bjp_o_ready = 1'b0;
    drive(1'b1, '0, '0, '0, 32'h1000, mk(BJP_JUMP, 1'b0, 1'b1));
    tick();
    drive(1'b1, '0, '0, '0, 32'h2000, mk(BJP_JUMP, 1'b0, 1'b1));
    tick();
    drive(1'b1, '0, '0, '0, 32'h3000, mk(BJP_JUMP, 1'b0, 1'b1));
    checks++;
    if ({bjp_i_ready, bjp_o_valid, bjp_o_redirect_pc} !== {2'b01, 32'h1000}) begin
      failures++;
      $display("FAIL bp_full: got ready=%b valid=%b head=%h want 0 1 1000",
               bjp_i_ready, bjp_o_valid, bjp_o_redirect_pc);
    end
    tick();
    checks++;
    if ({bjp_i_ready, bjp_o_redirect_pc} !== {1'b0, 32'h1000}) begin
      failures++;
      $display("FAIL bp_hold: got ready=%b head=%h want 0 1000", bjp_i_ready, bjp_o_redirect_pc);
    end
    bjp_o_ready = 1'b1;
    tick();
    bjp_o_ready = 1'b0;
    checks++;
    if ({bjp_i_ready, bjp_o_redirect_pc} !== {1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL bp_pop_full: got ready=%b head=%h want 1 2000", bjp_i_ready, bjp_o_redirect_pc);
    end
    tick();
    bjp_i_valid = 1'b0;
    checks++;
    if (bjp_i_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_third_accepted: got ready=%b want 0", bjp_i_ready);
    end
    bjp_o_ready = 1'b1;
    tick();
    checks++;
    if ({bjp_o_valid, bjp_o_redirect_pc} !== {1'b1, 32'h3000}) begin
      failures++;
      $display("FAIL bp_order: got valid=%b head=%h want 1 3000", bjp_o_valid, bjp_o_redirect_pc);
    end
    tick();
    checks++;
    if (bjp_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: got valid=%b want 0", bjp_o_valid);
    end
  endtask

  task automatic test_flush();
    for (int fill = 1; fill <= 2; fill++) begin
      bjp_o_ready = 1'b0;
      for (int j = 0; j < fill; j++) begin
        drive(1'b1, '0, '0, '0, 32'h500 + 32'(j), mk(BJP_JUMP, 1'b0, 1'b0));
        tick();
      end
      drive(1'b1, '0, '0, '0, 32'h900, mk(BJP_JUMP, 1'b0, 1'b0));
      bjp_o_ready = 1'b1;
      bjp_i_flush = 1'b1;
      tick();
      bjp_i_flush = 1'b0;
      bjp_i_valid = 1'b0;
      checks++;
      if ({bjp_o_valid, bjp_i_ready} !== 2'b01) begin
        failures++;
        $display("FAIL flush_%0d: got valid/ready=%b%b want 01", fill, bjp_o_valid, bjp_i_ready);
      end
      tick();
      checks++;
      if (bjp_o_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_drop_%0d: got valid=%b want 0", fill, bjp_o_valid);
      end
    end
  endtask

  task automatic test_random();
    exp_t        q [$];
    exp_t        e;
    logic [31:0] rs1, rs2, imm, pc;
    logic [8:0]  info;
    bit          v, rdy, fl, acc, pop;
    for (int n = 0; n < 1500; n++) begin
      rs1  = rnd_operand();
      rs2  = ($urandom_range(0, 3) == 0) ? rs1 : rnd_operand();
      imm  = rnd_operand();
      pc   = $urandom;
      info = rnd_info();
      v    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      drive(v, rs1, rs2, imm, pc, info);
      bjp_o_ready = rdy;
      bjp_i_flush = fl;
      checks++;
      if ({bjp_o_valid, bjp_i_ready} !== {q.size() != 0, q.size() < DEPTH}) begin
        failures++;
        $display("FAIL rand_hs cycle %0d: got valid/ready=%b%b want %b%b", n, bjp_o_valid,
                 bjp_i_ready, q.size() != 0, q.size() < DEPTH);
      end
      if (q.size() != 0) begin
        checks++;
        if ({bjp_o_cmt_bjp, bjp_o_taken, bjp_o_mispred, bjp_o_wbck_en, bjp_o_cmt_prdt,
             bjp_o_redirect_pc, bjp_o_wbck_wdat} !==
            {1'b1, q[0].taken, q[0].mispred, q[0].wbck_en, q[0].prdt, q[0].redirect,
             q[0].wdat}) begin
          failures++;
          $display("FAIL rand_head cycle %0d: got t=%b m=%b w=%b p=%b rpc=%h wdat=%h want t=%b m=%b w=%b p=%b rpc=%h wdat=%h",
                   n, bjp_o_taken, bjp_o_mispred, bjp_o_wbck_en, bjp_o_cmt_prdt,
                   bjp_o_redirect_pc, bjp_o_wbck_wdat, q[0].taken, q[0].mispred,
                   q[0].wbck_en, q[0].prdt, q[0].redirect, q[0].wdat);
        end
      end
      acc = v && (q.size() < DEPTH);
      pop = rdy && (q.size() != 0);
      e   = model(rs1, rs2, imm, pc, info);
      tick();
      if (fl) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    bjp_i_valid = 1'b0;
    bjp_i_flush = 1'b0;
    bjp_o_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    checks++;
    if (bjp_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: got valid=%b want 0", bjp_o_valid);
    end
  endtask

  task automatic test_reset_mid();
    bjp_o_ready = 1'b0;
    drive(1'b1, '0, '0, '0, 32'h700, mk(BJP_JUMP, 1'b0, 1'b0));
    tick();
    bjp_i_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bjp_o_valid, bjp_i_ready, bjp_o_wbck_wdat} !== {2'b01, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid: got valid=%b ready=%b wdat=%h want 0 1 0", bjp_o_valid,
               bjp_i_ready, bjp_o_wbck_wdat);
    end
    rst = 1'b0;
    tick();
  endtask

`ifdef BJP_PERF_EN
  task automatic test_perf();
    logic [8:0] inf [4];
    inf[0] = mk(BJP_JUMP, 1'b0, 1'b1);
    inf[1] = mk(BJP_BEQ, 1'b0, 1'b1);
    inf[2] = mk(BJP_BNE, 1'b0, 1'b0);
    inf[3] = mk(BJP_BEQ, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    bjp_o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd3, 32'd3, 32'h10, 32'h100, inf[i]);
      tick();
    end
    bjp_i_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bjp_o_perf_cnt, bjp_o_perf_mis} !== {32'd4, 32'd1}) begin
      failures++;
      $display("FAIL perf_counts: got cnt=%0d mis=%0d want 4 1", bjp_o_perf_cnt, bjp_o_perf_mis);
    end
    bjp_o_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd3, 32'h10, 32'h100, inf[3]);
    tick();
    bjp_i_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bjp_o_perf_cnt, bjp_o_perf_mis, bjp_o_valid} !== 65'd0) begin
      failures++;
      $display("FAIL perf_reset: got cnt=%0d mis=%0d valid=%b want 0 0 0", bjp_o_perf_cnt,
               bjp_o_perf_mis, bjp_o_valid);
    end
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
`ifdef BJP_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
